uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter, successor to the fixed 8N1 one-bit-per-clock TX.
//  Adds a baud-rate divider, configurable data width, optional parity and 1/2 stop bits.
//  Adds a valid/ready byte handshake with back-to-back framing.
//  Sits between a byte source (FIFO, command encoder) and the board TX pin; LSB first.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per serial bit (100 MHz / 115200); legal >= 2
//  DATA_BITS     8    data bits per frame; legal 5..9
//  PARITY        0    0 = none, 1 = odd, 2 = even (uart_pkg constants)
//  STOP_BITS     1    stop bits per frame; legal 1 or 2
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          asynchronous, active-high reset
//  din        in   DATA_BITS  frame payload, sampled on the accepting edge only
//  din_valid  in   1          source has a payload on din
//  din_ready  out  1          block can accept; transfer = din_valid & din_ready at posedge
//  tx_data    out  1          serial line, registered, idle high
//  busy       out  1          frame in progress (START..STOP)
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame):
//   - state=IDLE, tx_data=1, busy=0, bit/baud counters=0; the frame is abandoned.
//   - No transfer is accepted while rst=1.
//  FSM states: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE/START.
//  IDLE: tx_data=1, din_ready=1.
//   - Accepting edge: latch din into shift reg, compute parity, tx_data<=0, busy<=1, ->START.
//   - Start bit is visible from the cycle after the handshake (latency 1 clk).
//  Each bit is held exactly CLKS_PER_BIT cycles.
//   - Baud counter restarts at every bit boundary; it is not free-running.
//  DATA: DATA_BITS bits, din[0] first, shift reg shifts right on each bit boundary.
//  PARITY: even -> ^data; odd -> ~^data; computed from the latched payload, not from live din.
//  STOP: tx_data=1 for STOP_BITS*CLKS_PER_BIT cycles.
//  Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
//  din_ready (combinational from registered state only) = IDLE, or the final clk of the final stop bit.
//  Transfer in the final stop clk: go straight to START, tx_data<=0, busy stays 1, zero idle gap.
//  Otherwise the final stop clk -> IDLE, busy<=0.
//  din changes after acceptance have no effect on the frame in flight.
//  din_valid may drop without a transfer; no payload is held.
//  Illegal parameter values -> elaboration-time $error; no runtime checking.
//  Bit counter width $clog2(DATA_BITS+1).
//  Baud counter width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1; wraps to 0 at bit end.
// STRUCTURE
//  uart_pkg: PARITY_NONE/ODD/EVEN constants and TX state encoding localparams.
//   - The future uart_rx_param shares this package.
//  Sub-module uart_baud_cnt (CLKS_PER_BIT): clk, rst, clr, bit_end.
//   - Pulses bit_end on count CLKS_PER_BIT-1; clr restarts the count.
//   - The RX successor reuses it.
//  Top: FSM, shift reg, bit counter, parity reg, output reg.
// TESTING (bench: CLKS_PER_BIT=4; edge-count checks on tx_data, din_ready, busy)
//  1. 8N1, din=8'h55 single transfer
//     -> tx_data 0,1,0,1,0,1,0,1,0,1, each 4 clks.
//     -> busy high 40 clks, then IDLE.
//  2. PARITY=2, din=8'h07 -> parity bit 1; PARITY=1, same din -> 0; frame 44 clks.
//  3. Back-to-back 8'hA5 then 8'h3C, din_valid held high
//     -> second start bit begins exactly 40 clks after first.
//     -> no idle-high gap; busy never drops.
//  4. Async reset pulse mid-DATA (bit 3 of 8'hFF)
//     -> tx_data=1, busy=0, din_ready=1 immediately without clk.
//     -> next transfer after release sends a clean frame.
//  5. DATA_BITS=7, STOP_BITS=2, din=7'h41 -> 0,1,0,0,0,0,0,1,1,1, 40 clks.
//  6. Payload stability: din changes every clk after acceptance of 8'h81
//     -> line still shows 8'h81; din_valid pulsed while busy (not last clk) is ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX state encoding and parity helper.
// Also imported by the receive side so both ends agree on parity semantics.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } tx_state_e;

  // Payload is zero-extended to 9 bits, so the unused upper bits never disturb the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input int mode);
    logic p;
    if (mode == PARITY_ODD) begin
      p = ~^data;
    end else begin
      p = ^data;
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// clr restarts the count so every bit boundary lines up with the frame, not a free-running tick.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_r;

  // Bit-period counter, wraps to zero at the end of every bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr || (cnt_r == LAST)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign bit_end = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready byte intake, LSB first,
// optional parity, 1 or 2 stop bits and gap-free back-to-back framing.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 tx_data,
  output logic                 busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if ((PARITY != PARITY_NONE) && (PARITY != PARITY_ODD) && (PARITY != PARITY_EVEN)) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  tx_state_e state_r, state_nxt;
  logic [DATA_BITS-1:0] shreg_r, shreg_nxt;
  logic [BW-1:0] bit_cnt_r, bit_cnt_nxt;
  logic par_r, par_nxt;
  logic tx_r, tx_nxt;
  logic busy_r, busy_nxt;
  logic bit_end;
  logic accept;
  logic baud_clr;

  // Ready in the last stop clock is what allows a new start bit with no idle gap.
  assign din_ready = (state_r == S_IDLE) ||
                     ((state_r == S_STOP) && bit_end && (bit_cnt_r == LAST_STOP));
  assign accept    = din_valid && din_ready;
  assign baud_clr  = (state_r == S_IDLE) || accept;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (baud_clr),
    .bit_end(bit_end)
  );

  // Frame sequencing: next state, shift register, bit counter and line level.
  always_comb begin
    state_nxt   = state_r;
    shreg_nxt   = shreg_r;
    bit_cnt_nxt = bit_cnt_r;
    par_nxt     = par_r;
    tx_nxt      = tx_r;
    busy_nxt    = busy_r;
    if (accept) begin
      state_nxt   = S_START;
      shreg_nxt   = din;
      par_nxt     = calc_parity(9'(din), PARITY);
      bit_cnt_nxt = '0;
      tx_nxt      = 1'b0;
      busy_nxt    = 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          tx_nxt   = 1'b1;
          busy_nxt = 1'b0;
        end
        S_START: begin
          if (bit_end) begin
            state_nxt   = S_DATA;
            tx_nxt      = shreg_r[0];
            bit_cnt_nxt = '0;
          end else begin
            tx_nxt = 1'b0;
          end
        end
        S_DATA: begin
          if (bit_end && (bit_cnt_r == LAST_DATA)) begin
            bit_cnt_nxt = '0;
            if (PARITY != PARITY_NONE) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_r;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else if (bit_end) begin
            shreg_nxt   = shreg_r >> 1;
            tx_nxt      = shreg_r[1];
            bit_cnt_nxt = bit_cnt_r + BIT_ONE;
          end else begin
            tx_nxt = tx_r;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_nxt   = S_STOP;
            tx_nxt      = 1'b1;
            bit_cnt_nxt = '0;
          end else begin
            tx_nxt = par_r;
          end
        end
        S_STOP: begin
          if (bit_end && (bit_cnt_r == LAST_STOP)) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            tx_nxt    = 1'b1;
          end else if (bit_end) begin
            bit_cnt_nxt = bit_cnt_r + BIT_ONE;
          end else begin
            tx_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
          tx_nxt      = 1'b1;
          busy_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      par_r     <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      shreg_r   <= shreg_nxt;
      bit_cnt_r <= bit_cnt_nxt;
      par_r     <= par_nxt;
      tx_r      <= tx_nxt;
      busy_r    <= busy_nxt;
    end
  end

  assign tx_data = tx_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at 4 clks/bit,
// a line monitor decoding every frame, and cycle counts on busy/din_ready.
module tb_uart_tx_param;

  localparam int CPB = 4;

  typedef struct {
    int          dut;
    logic [10:0] bits;
    int          start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] din [4];
  logic [3:0] din_valid = 4'b0000;
  logic [3:0] din_ready;
  logic [3:0] tx;
  logic [3:0] busy;

  int checks   = 0;
  int failures = 0;

  frame_t exp_q[$];
  frame_t rx_q[$];

  int          cyc = 0;
  logic        rx_act   [4];
  int          rx_pos   [4] = '{0, 0, 0, 0};
  logic [10:0] rx_bits  [4];
  int          rx_start [4] = '{0, 0, 0, 0};
  int          idle_cnt [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .din(din[0][7:0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .tx_data(tx[0]), .busy(busy[0]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .din(din[1][7:0]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .tx_data(tx[1]), .busy(busy[1]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .din(din[2][7:0]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .tx_data(tx[2]), .busy(busy[2]));
  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .din(din[3][6:0]), .din_valid(din_valid[3]),
    .din_ready(din_ready[3]), .tx_data(tx[3]), .busy(busy[3]));

  function automatic int nbits(input int k);
    return (k == 1 || k == 2) ? 11 : 10;
  endfunction

  // Expected line bits, index 0 = start bit, built from the frame format alone.
  function automatic logic [10:0] exp_frame(input int k, input logic [8:0] d);
    logic [10:0] f = '0;
    logic p = 1'b0;
    int pos = 1;
    int db  = (k == 3) ? 7 : 8;
    int nst = (k == 3) ? 2 : 1;
    for (int i = 0; i < db; i++) begin
      f[pos] = d[i];
      p = p ^ d[i];
      pos++;
    end
    if (k == 1) begin
      f[pos] = p;
      pos++;
    end else if (k == 2) begin
      f[pos] = ~p;
      pos++;
    end
    for (int j = 0; j < nst; j++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Line monitor: samples each bit mid-period and queues the decoded frame.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        rx_act[k] <= 1'b0;
        rx_pos[k] <= 0;
      end else begin
        if (!busy[k]) idle_cnt[k] <= idle_cnt[k] + 1;
        if (rx_act[k] !== 1'b1) begin
          if (tx[k] == 1'b0) begin
            rx_act[k]   <= 1'b1;
            rx_pos[k]   <= 1;
            rx_bits[k]  <= '0;
            rx_start[k] <= cyc;
          end
        end else begin
          rx_pos[k] <= rx_pos[k] + 1;
          if (rx_pos[k] % CPB == CPB / 2) rx_bits[k][rx_pos[k] / CPB] <= tx[k];
          if (rx_pos[k] == CPB * (nbits(k) - 1) + CPB / 2 + 1) begin
            rx_act[k] <= 1'b0;
            rx_q.push_back('{dut: k, bits: rx_bits[k], start: rx_start[k]});
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [8:0] d, input bit hold, input bit expect_frame);
    int t = 0;
    din[k] = d;
    din_valid[k] = 1'b1;
    while (!din_ready[k] && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("handshake_wait", (t >= 200) ? 32'd1 : 32'd0, 32'd0);
    if (expect_frame) exp_q.push_back('{dut: k, bits: exp_frame(k, d), start: 0});
    @(posedge clk);
    #1;
    if (!hold) din_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input bit wiggle, output int n);
    bit done = 1'b0;
    n = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (!busy[k]) begin
        done = 1'b1;
        break;
      end
      if (wiggle) begin
        din[k] = 9'($urandom);
        din_valid[k] = (n < 36) && (n % 7 == 3);
      end
      n++;
    end
    if (!done) check_val("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    frame_t r;
    int idx;
    while (rx_q.size() > 0) begin
      r = rx_q.pop_front();
      idx = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
        if (idx < 0 && exp_q[i].dut == r.dut) idx = i;
      end
      if (idx < 0) begin
        check_val($sformatf("unexpected_frame_d%0d", r.dut), {21'd0, r.bits}, 32'hFFFF_FFFF);
      end else begin
        check_val($sformatf("frame_d%0d", r.dut), {21'd0, r.bits}, {21'd0, exp_q[idx].bits});
        exp_q.delete(idx);
      end
    end
  endtask

  initial begin
    int n;
    int idle0;
    for (int k = 0; k < 4; k++) din[k] = '0;

    repeat (3) @(negedge clk);
    check_val("rst_tx", {31'd0, tx[0]}, 32'd1);
    check_val("rst_busy", {31'd0, busy[0]}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("idle_tx_d%0d", k), {31'd0, tx[k]}, 32'd1);
      check_val($sformatf("idle_busy_d%0d", k), {31'd0, busy[k]}, 32'd0);
      check_val($sformatf("idle_ready_d%0d", k), {31'd0, din_ready[k]}, 32'd1);
    end

    // 8N1 single frame
    send(0, 9'h055, 1'b0, 1'b1);
    wait_idle(0, 1'b0, n);
    check_val("busy_len_8n1", n, 32'd40);
    repeat (2) @(negedge clk);
    drain();

    // even and odd parity on the same payload
    send(1, 9'h007, 1'b0, 1'b1);
    wait_idle(1, 1'b0, n);
    check_val("busy_len_8e1", n, 32'd44);
    send(2, 9'h007, 1'b0, 1'b1);
    wait_idle(2, 1'b0, n);
    check_val("busy_len_8o1", n, 32'd44);
    repeat (2) @(negedge clk);
    drain();

    // back-to-back with din_valid held high
    send(0, 9'h0A5, 1'b1, 1'b1);
    idle0 = idle_cnt[0];
    send(0, 9'h03C, 1'b0, 1'b1);
    check_val("b2b_idle_cycles", idle_cnt[0] - idle0, 32'd0);
    wait_idle(0, 1'b0, n);
    check_val("b2b_second_busy", n, 32'd40);
    repeat (2) @(negedge clk);
    check_val("b2b_frame_count", rx_q.size(), 32'd2);
    if (rx_q.size() >= 2) check_val("b2b_start_gap", rx_q[1].start - rx_q[0].start, 32'd40);
    drain();

    // asynchronous reset in the middle of data bit 3
    send(0, 9'h0FF, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_val("arst_tx", {31'd0, tx[0]}, 32'd1);
    check_val("arst_busy", {31'd0, busy[0]}, 32'd0);
    check_val("arst_ready", {31'd0, din_ready[0]}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send(0, 9'h03A, 1'b0, 1'b1);
    wait_idle(0, 1'b0, n);
    check_val("post_rst_busy", n, 32'd40);
    repeat (2) @(negedge clk);
    drain();

    // 7 data bits, 2 stop bits
    send(3, 9'h041, 1'b0, 1'b1);
    wait_idle(3, 1'b0, n);
    check_val("busy_len_7n2", n, 32'd40);
    repeat (2) @(negedge clk);
    drain();

    // payload stability with din wiggling and stray din_valid pulses
    send(0, 9'h081, 1'b0, 1'b1);
    wait_idle(0, 1'b1, n);
    din_valid[0] = 1'b0;
    check_val("stable_busy_len", n, 32'd40);
    repeat (10) @(negedge clk);
    check_val("stable_no_extra", {31'd0, busy[0]}, 32'd0);
    drain();

    check_val("missing_frames", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
